// File: rtl/pc_unit.sv
// Program-counter unit: stall-able, redirectable PC with prioritised next-PC select.
// Define PC_RAS_EN to add the circular return-address stack used by CALL/RET.
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               STEP         = 4,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             STALL,
   input  logic             BR_TAKEN,
   input  logic [WIDTH-1:0] BR_TARGET,
   input  logic             JMP,
   input  logic             CALL,
   input  logic             RET,
   input  logic [WIDTH-1:0] JMP_TARGET,
   output logic [WIDTH-1:0] PC,
   output logic [WIDTH-1:0] PC_PLUS,
   output logic [WIDTH-1:0] PC_NEXT,
   output logic             RAS_EMPTY,
   output logic             RAS_FULL,
   output logic             RAS_ERR
);

   assign PC_PLUS = PC + WIDTH'(STEP);

`ifdef PC_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);
   localparam logic [PW-1:0] PTR_MAX = PW'(RAS_DEPTH - 1);

   // top points at the next free slot; when full it also points at the oldest entry
   logic [WIDTH-1:0] stack [RAS_DEPTH];
   logic [PW-1:0]    top;
   logic [PW-1:0]    top_inc;
   logic [PW-1:0]    top_dec;
   logic [CW-1:0]    count;
   logic             do_pop;
   logic             do_push;
   logic             underflow;
   logic             overflow;
   logic             ras_err_q;

   assign top_inc   = (top == PTR_MAX) ? '0 : top + 1'b1;
   assign top_dec   = (top == '0) ? PTR_MAX : top - 1'b1;
   assign RAS_EMPTY = (count == '0);
   assign RAS_FULL  = (count == CNT_MAX);
   assign RAS_ERR   = ras_err_q;

   // a RET on an empty stack is not a transfer, so a simultaneous CALL still pushes
   assign do_pop    = RET && !RAS_EMPTY;
   assign do_push   = CALL && !do_pop;
   assign underflow = RET && RAS_EMPTY;
   assign overflow  = do_push && RAS_FULL;

   always_comb begin
      PC_NEXT = PC_PLUS;
      if (do_pop)
         PC_NEXT = stack[top_dec];
      else if (CALL || JMP)
         PC_NEXT = JMP_TARGET;
      else if (BR_TAKEN)
         PC_NEXT = BR_TARGET;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         top       <= '0;
         count     <= '0;
         ras_err_q <= 1'b0;
      end else if (STALL) begin
         ras_err_q <= 1'b0;
      end else begin
         ras_err_q <= underflow || overflow;
         if (do_pop) begin
            top   <= top_dec;
            count <= count - 1'b1;
         end else if (do_push) begin
            top <= top_inc;
            if (!RAS_FULL)
               count <= count + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && !STALL && do_push)
         stack[top] <= PC_PLUS;
   end
`else
   logic unused_ok;

   // without a stack, CALL is a plain jump and RET falls through sequentially
   assign unused_ok = RET ^ (RAS_DEPTH > 1);
   assign RAS_EMPTY = 1'b1;
   assign RAS_FULL  = 1'b0;
   assign RAS_ERR   = 1'b0;

   always_comb begin
      PC_NEXT = PC_PLUS;
      if (CALL || JMP)
         PC_NEXT = JMP_TARGET;
      else if (BR_TAKEN)
         PC_NEXT = BR_TARGET;
   end
`endif

   always_ff @(posedge CLK) begin
      if (RST)
         PC <= RESET_VECTOR;
      else if (!STALL)
         PC <= PC_NEXT;
   end

endmodule
